// File: rtl/mem_wb_pipeline_register.sv
// MEM/WB pipeline boundary register: feeds the write-back 3:1 mux and register-file write controls.
// Optional performance counters are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_pipeline_register #(
  parameter int NBits       = 32,
  parameter int RegAddrBits = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Stall_i,
  input  logic                   Flush_i,
  input  logic                   Valid_i,
  input  logic [NBits-1:0]       ALU_Result_i,
  input  logic [NBits-1:0]       Mem_Read_Data_i,
  input  logic [NBits-1:0]       PC_Plus_4_i,
  input  logic [1:0]             WB_Sel_i,
  input  logic                   Reg_Write_i,
  input  logic [RegAddrBits-1:0] Write_Reg_i,
  output logic [NBits-1:0]       Mux_Data_0_o,
  output logic [NBits-1:0]       Mux_Data_1_o,
  output logic [NBits-1:0]       Mux_Data_2_o,
  output logic [1:0]             WB_Sel_o,
  output logic [RegAddrBits-1:0] Write_Reg_o,
  output logic                   Reg_Write_o,
  output logic                   Valid_o,
  output logic                   Illegal_Sel_o
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]            Retired_Count_o,
  output logic [31:0]            Bubble_Count_o
`endif
);

  logic sel_illegal;
  logic write_qual;

  assign sel_illegal = (WB_Sel_i == 2'd3);
  // Writes to x0 and illegal selects are blocked before they reach the register file.
  assign write_qual  = Valid_i & Reg_Write_i & (Write_Reg_i != '0) & ~sel_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Mux_Data_0_o  <= '0;
      Mux_Data_1_o  <= '0;
      Mux_Data_2_o  <= '0;
      WB_Sel_o      <= '0;
      Write_Reg_o   <= '0;
      Reg_Write_o   <= 1'b0;
      Valid_o       <= 1'b0;
      Illegal_Sel_o <= 1'b0;
    end else if (Flush_i) begin
      // Data paths still load so bubble contents are deterministic.
      Mux_Data_0_o  <= ALU_Result_i;
      Mux_Data_1_o  <= Mem_Read_Data_i;
      Mux_Data_2_o  <= PC_Plus_4_i;
      WB_Sel_o      <= '0;
      Write_Reg_o   <= '0;
      Reg_Write_o   <= 1'b0;
      Valid_o       <= 1'b0;
      Illegal_Sel_o <= 1'b0;
    end else if (Stall_i) begin
      Illegal_Sel_o <= 1'b0;
    end else begin
      Mux_Data_0_o  <= ALU_Result_i;
      Mux_Data_1_o  <= Mem_Read_Data_i;
      Mux_Data_2_o  <= PC_Plus_4_i;
      WB_Sel_o      <= WB_Sel_i;
      Write_Reg_o   <= Write_Reg_i;
      Reg_Write_o   <= write_qual;
      Valid_o       <= Valid_i;
      Illegal_Sel_o <= Valid_i & sel_illegal;
    end
  end

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] bubble_cnt;

  // Stalled cycles are neither retirements nor bubbles; counters wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else if (Flush_i) begin
      bubble_cnt  <= bubble_cnt + 32'd1;
    end else if (!Stall_i) begin
      if (Valid_i) retired_cnt <= retired_cnt + 32'd1;
      else         bubble_cnt  <= bubble_cnt + 32'd1;
    end
  end

  assign Retired_Count_o = retired_cnt;
  assign Bubble_Count_o  = bubble_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_pipeline_register.sv
// Scoreboard bench for mem_wb_pipeline_register: driver queues hand-computed expectations,
// a monitor pops one per clock after the edge and compares.
module tb_mem_wb_pipeline_register;

  typedef struct packed {
    logic        chk_data;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  sel;
    logic [4:0]  wreg;
    logic        rw;
    logic        v;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [31:0] alu = '0, mem = '0, pc = '0;
  logic [1:0]  sel = '0;
  logic        rw = 1'b0;
  logic [4:0]  wreg = '0;

  logic [31:0] d0_q, d1_q, d2_q;
  logic [1:0]  sel_q;
  logic [4:0]  wreg_q;
  logic        rw_q, v_q, ill_q;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] retired_q, bubble_q;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mem_wb_pipeline_register #(.NBits(32), .RegAddrBits(5)) dut (
    .clk(clk), .reset(reset), .Stall_i(stall), .Flush_i(flush), .Valid_i(valid),
    .ALU_Result_i(alu), .Mem_Read_Data_i(mem), .PC_Plus_4_i(pc), .WB_Sel_i(sel),
    .Reg_Write_i(rw), .Write_Reg_i(wreg),
    .Mux_Data_0_o(d0_q), .Mux_Data_1_o(d1_q), .Mux_Data_2_o(d2_q), .WB_Sel_o(sel_q),
    .Write_Reg_o(wreg_q), .Reg_Write_o(rw_q), .Valid_o(v_q), .Illegal_Sel_o(ill_q)
`ifdef MEM_WB_PERF_CNT_EN
    , .Retired_Count_o(retired_q), .Bubble_Count_o(bubble_q)
`endif
  );

  function automatic exp_t mk(input logic cd, input logic [31:0] a, m, p,
                              input logic [1:0] s, input logic [4:0] w,
                              input logic r, input logic vv, input logic il);
    exp_t e;
    e = '{chk_data: cd, d0: a, d1: m, d2: p, sel: s, wreg: w, rw: r, v: vv, ill: il};
    return e;
  endfunction

  task automatic cmp(input string name, input exp_t e);
    logic [9:0]  ctl_act, ctl_exp;
    logic [95:0] dat_act, dat_exp;
    ctl_act = {sel_q, wreg_q, rw_q, v_q, ill_q};
    ctl_exp = {e.sel, e.wreg, e.rw, e.v, e.ill};
    dat_act = {d0_q, d1_q, d2_q};
    dat_exp = {e.d0, e.d1, e.d2};
    checks++;
    if (ctl_act !== ctl_exp || (e.chk_data && dat_act !== dat_exp)) begin
      errors++;
      $display("FAIL %s: got ctl=%b data=%h expected ctl=%b data=%h (data checked=%0b)",
               name, ctl_act, dat_act, ctl_exp, dat_exp, e.chk_data);
    end
  endtask

  // Monitor: one queued expectation is consumed per clock edge.
  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("scoreboard", e);
    end
  end

  task automatic step(input logic st, input logic fl, input logic vv,
                      input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                      input logic [1:0] s, input logic r, input logic [4:0] w,
                      input exp_t e);
    @(negedge clk);
    stall = st; flush = fl; valid = vv; alu = a; mem = m; pc = p;
    sel = s; rw = r; wreg = w;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t zero, hold5, hold_ill;
    zero = mk(1'b1, '0, '0, '0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset held with all inputs high: nothing may leak through.
    stall = 1'b0; flush = 1'b0; valid = 1'b1; alu = '1; mem = '1; pc = '1;
    sel = 2'd3; rw = 1'b1; wreg = 5'd31;
    repeat (3) begin
      @(negedge clk);
      cmp("reset_hold", zero);
    end
    // First capture on the first edge after release (Flush/Stall low, illegal select 3).
    @(negedge clk);
    reset = 1'b0;
    q.push_back(mk(1'b1, '1, '1, '1, 2'd3, 5'd31, 1'b0, 1'b1, 1'b1));

    step(0, 0, 1, 32'h00000010, 32'hDEADBEEF, 32'h00400004, 2'd1, 1, 5'd8,
         mk(1, 32'h00000010, 32'hDEADBEEF, 32'h00400004, 2'd1, 5'd8, 1, 1, 0));
    step(0, 0, 1, 32'h00000020, 32'h00000030, 32'h00000040, 2'd0, 1, 5'd0,
         mk(1, 32'h00000020, 32'h00000030, 32'h00000040, 2'd0, 5'd0, 0, 1, 0));
    step(0, 0, 1, 32'h00000001, 32'h00000002, 32'h00000003, 2'd3, 1, 5'd5,
         mk(1, 32'h00000001, 32'h00000002, 32'h00000003, 2'd3, 5'd5, 0, 1, 1));
    step(0, 0, 1, 32'h00000004, 32'h00000005, 32'h00000006, 2'd2, 0, 5'd9,
         mk(1, 32'h00000004, 32'h00000005, 32'h00000006, 2'd2, 5'd9, 0, 1, 0));

    hold5 = mk(1, 32'h11111111, 32'h11111111, 32'h11111111, 2'd0, 5'd3, 1, 1, 0);
    step(0, 0, 1, 32'h11111111, 32'h11111111, 32'h11111111, 2'd0, 1, 5'd3, hold5);
    repeat (3)
      step(1, 0, 1, 32'h22222222, 32'h22222222, 32'h22222222, 2'd1, 1, 5'd4, hold5);
    step(0, 0, 1, 32'h22222222, 32'h22222222, 32'h22222222, 2'd1, 1, 5'd4,
         mk(1, 32'h22222222, 32'h22222222, 32'h22222222, 2'd1, 5'd4, 1, 1, 0));

    // Illegal select, then a stall: the pulse must not repeat while held.
    step(0, 0, 1, 32'h33333333, 32'h33333333, 32'h33333333, 2'd3, 1, 5'd7,
         mk(1, 32'h33333333, 32'h33333333, 32'h33333333, 2'd3, 5'd7, 0, 1, 1));
    hold_ill = mk(1, 32'h33333333, 32'h33333333, 32'h33333333, 2'd3, 5'd7, 0, 1, 0);
    step(1, 0, 1, 32'h66666666, 32'h66666666, 32'h66666666, 2'd1, 1, 5'd2, hold_ill);

    // Flush wins over stall; data contents are don't-care.
    step(1, 1, 1, 32'h44444444, 32'h44444444, 32'h44444444, 2'd1, 1, 5'd6,
         mk(0, '0, '0, '0, 2'd0, 5'd0, 0, 0, 0));
    step(0, 1, 1, 32'h77777777, 32'h77777777, 32'h77777777, 2'd3, 1, 5'd12,
         mk(0, '0, '0, '0, 2'd0, 5'd0, 0, 0, 0));
    // Invalid slot latches all fields but raises no enables.
    step(0, 0, 0, 32'h55555555, 32'h55555555, 32'h55555555, 2'd3, 1, 5'd10,
         mk(1, 32'h55555555, 32'h55555555, 32'h55555555, 2'd3, 5'd10, 0, 0, 0));
    step(0, 0, 1, 32'h0000ABCD, 32'h12345678, 32'h00400100, 2'd2, 1, 5'd31,
         mk(1, 32'h0000ABCD, 32'h12345678, 32'h00400100, 2'd2, 5'd31, 1, 1, 0));
    drain();

    // Asynchronous reset between edges.
    @(negedge clk);
    stall = 0; flush = 0; valid = 1; alu = 32'h99; mem = 32'h98; pc = 32'h97;
    sel = 2'd0; rw = 1; wreg = 5'd1;
    @(posedge clk);
    #1;
    cmp("pre_async_reset", mk(1, 32'h99, 32'h98, 32'h97, 2'd0, 5'd1, 1, 1, 0));
    #2 reset = 1'b1;
    #1;
    cmp("async_reset", zero);
    @(negedge clk);
    reset = 1'b0;

`ifdef MEM_WB_PERF_CNT_EN
    reset = 1'b1;
    #1;
    checks++;
    if (retired_q !== 32'd0 || bubble_q !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got %h/%h expected 0/0", retired_q, bubble_q);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      stall = (i >= 12 && i < 15);
      flush = (i == 10 || i == 11);
      valid = (i != 15);
      @(negedge clk);
    end
    stall = 1'b1;
    checks++;
    if (retired_q !== 32'd10 || bubble_q !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: got retired=%0d bubble=%0d expected 10/3", retired_q, bubble_q);
    end
    force dut.retired_cnt = 32'hFFFFFFFF;
    #1 release dut.retired_cnt;
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; valid = 1'b1;
    @(negedge clk);
    stall = 1'b1;
    checks++;
    if (retired_q !== 32'd0 || bubble_q !== 32'd3) begin
      errors++;
      $display("FAIL perf_wrap: got retired=%h bubble=%0d expected 0/3", retired_q, bubble_q);
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
